uart_dbus_master: RTL and testbench

- Host-side debug and firmware-load bridge that turns byte commands from the uart_lite RX port into word read/write transactions on the VexRiscv-style dBus.
- Acts as initiator on the same cmd/rsp protocol that the CPU data bus uses; replies to the host through the uart_lite TX port.
- Sits in the top level beside the CPU, muxed onto the RAM/IO dBus responder while `busy` is high or the CPU is held in reset.

---
 rtl/uart_dbus_pkg.sv | 20 ++
 rtl/uart_tx_seq.sv | 50 +++++
 rtl/uart_dbus_master.sv | 191 +++++++++++++++++++
 tb/tb_uart_dbus_master.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_dbus_pkg.sv
// Shared constants and FSM state type for the UART-to-dBus debug bridge.
package uart_dbus_pkg;

    localparam logic [7:0] OP_WRITE = 8'h57;
    localparam logic [7:0] OP_READ  = 8'h52;
    localparam logic [7:0] RSP_ACK  = 8'h06;
    localparam logic [7:0] RSP_NAK  = 8'h15;

    localparam logic [1:0] DBUS_SIZE_WORD = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_GET_ADDR,
        S_GET_DATA,
        S_CMD,
        S_RSP_WAIT,
        S_TX
    } state_e;

endpackage

// File: rtl/uart_tx_seq.sv
// Reply byte sequencer: holds up to four bytes and hands them to the UART
// transmitter LSB first, one single-cycle strobe per byte.
module uart_tx_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_i,
    input  logic [31:0] bytes_i,
    input  logic [2:0]  len_i,
    input  logic        tx_rdy_i,
    output logic        tx_vld_o,
    output logic [7:0]  tx_data_o,
    output logic        done_o
);

    logic [31:0] buf_q;
    logic [2:0]  left_q;
    logic        tx_vld_q;
    logic [7:0]  tx_data_q;
    logic        done_q;

    // Strobe the next byte when the transmitter is idle; skipping the cycle
    // right after a strobe tolerates tx_rdy falling one cycle late.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_q     <= '0;
            left_q    <= '0;
            tx_vld_q  <= 1'b0;
            tx_data_q <= '0;
            done_q    <= 1'b0;
        end else begin
            tx_vld_q <= 1'b0;
            done_q   <= 1'b0;
            if (load_i) begin
                buf_q  <= bytes_i;
                left_q <= len_i;
            end else if (left_q != 3'd0 && tx_rdy_i && !tx_vld_q) begin
                tx_vld_q  <= 1'b1;
                tx_data_q <= buf_q[7:0];
                buf_q     <= {8'h00, buf_q[31:8]};
                left_q    <= left_q - 3'd1;
                done_q    <= (left_q == 3'd1);
            end
        end
    end

    assign tx_vld_o  = tx_vld_q;
    assign tx_data_o = tx_data_q;
    assign done_o    = done_q;

endmodule

// File: rtl/uart_dbus_master.sv
// Host debug/firmware-load bridge: parses 'W'/'R' byte frames from the UART
// and issues single-word dBus transactions, replying through the UART TX.
module uart_dbus_master
    import uart_dbus_pkg::*;
#(
    parameter int unsigned CLK_FREQ           = 100000000,
    parameter int unsigned BYTE_TIMEOUT_MS    = 100,
    parameter int unsigned RSP_TIMEOUT_CYCLES = 256,
    parameter int unsigned WL                 = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          rx_valid,
    input  logic [7:0]    rx_data,
    input  logic          tx_rdy,
    output logic          tx_vld,
    output logic [7:0]    tx_data,
    output logic          dbus_cmd_valid,
    input  logic          dbus_cmd_ready,
    output logic          dbus_cmd_payload_wr,
    output logic [WL-1:0] dbus_cmd_payload_address,
    output logic [WL-1:0] dbus_cmd_payload_data,
    output logic [1:0]    dbus_cmd_payload_size,
    input  logic          dbus_rsp_ready,
    input  logic          dbus_rsp_error,
    input  logic [WL-1:0] dbus_rsp_data,
    output logic          busy
);

    localparam logic        BT_EN    = (BYTE_TIMEOUT_MS != 0);
    localparam logic [31:0] BT_LAST  = 32'(CLK_FREQ / 1000 * BYTE_TIMEOUT_MS) - 32'd1;
    localparam logic [31:0] RSP_LAST = 32'(RSP_TIMEOUT_CYCLES) - 32'd1;

    state_e        state_q;
    logic [1:0]    cnt_q;
    logic [31:0]   btimer_q;
    logic [31:0]   rtimer_q;
    logic          busy_q;
    logic          cmd_valid_q;
    logic          cmd_wr_q;
    logic [WL-1:0] addr_q;
    logic [WL-1:0] wdata_q;
    logic          load_q;
    logic [31:0]   reply_q;
    logic [2:0]    reply_len_q;
    logic          tx_done;
    logic          bt_expired;

    assign bt_expired = BT_EN && (btimer_q == BT_LAST);

    // Frame parser and dBus transaction FSM; every output it drives is a register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            btimer_q    <= '0;
            rtimer_q    <= '0;
            busy_q      <= 1'b0;
            cmd_valid_q <= 1'b0;
            cmd_wr_q    <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            load_q      <= 1'b0;
            reply_q     <= '0;
            reply_len_q <= '0;
        end else begin
            load_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (rx_valid) begin
                        busy_q   <= 1'b1;
                        cnt_q    <= '0;
                        btimer_q <= '0;
                        if (rx_data == OP_WRITE || rx_data == OP_READ) begin
                            cmd_wr_q <= (rx_data == OP_WRITE);
                            state_q  <= S_GET_ADDR;
                        end else begin
                            reply_q     <= {24'h0, RSP_NAK};
                            reply_len_q <= 3'd1;
                            load_q      <= 1'b1;
                            state_q     <= S_TX;
                        end
                    end
                end
                S_GET_ADDR: begin
                    // Shifting in from the top leaves A3..A0 little-endian after four bytes.
                    if (rx_valid) begin
                        addr_q   <= {rx_data, addr_q[WL-1:8]};
                        btimer_q <= '0;
                        cnt_q    <= cnt_q + 2'd1;
                        if (cnt_q == 2'd3) begin
                            if (cmd_wr_q) begin
                                state_q <= S_GET_DATA;
                            end else begin
                                cmd_valid_q <= 1'b1;
                                state_q     <= S_CMD;
                            end
                        end
                    end else if (bt_expired) begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else begin
                        btimer_q <= btimer_q + 32'd1;
                    end
                end
                S_GET_DATA: begin
                    if (rx_valid) begin
                        wdata_q  <= {rx_data, wdata_q[WL-1:8]};
                        btimer_q <= '0;
                        cnt_q    <= cnt_q + 2'd1;
                        if (cnt_q == 2'd3) begin
                            cmd_valid_q <= 1'b1;
                            state_q     <= S_CMD;
                        end
                    end else if (bt_expired) begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else begin
                        btimer_q <= btimer_q + 32'd1;
                    end
                end
                S_CMD: begin
                    // A read response coincident with the transfer is taken here directly.
                    if (dbus_cmd_ready) begin
                        cmd_valid_q <= 1'b0;
                        rtimer_q    <= '0;
                        if (cmd_wr_q) begin
                            reply_q     <= {24'h0, RSP_ACK};
                            reply_len_q <= 3'd1;
                            load_q      <= 1'b1;
                            state_q     <= S_TX;
                        end else if (dbus_rsp_ready) begin
                            reply_q     <= dbus_rsp_error ? {24'h0, RSP_NAK} : dbus_rsp_data;
                            reply_len_q <= dbus_rsp_error ? 3'd1 : 3'd4;
                            load_q      <= 1'b1;
                            state_q     <= S_TX;
                        end else begin
                            state_q <= S_RSP_WAIT;
                        end
                    end
                end
                S_RSP_WAIT: begin
                    if (dbus_rsp_ready) begin
                        reply_q     <= dbus_rsp_error ? {24'h0, RSP_NAK} : dbus_rsp_data;
                        reply_len_q <= dbus_rsp_error ? 3'd1 : 3'd4;
                        load_q      <= 1'b1;
                        state_q     <= S_TX;
                    end else if (rtimer_q == RSP_LAST) begin
                        reply_q     <= {24'h0, RSP_NAK};
                        reply_len_q <= 3'd1;
                        load_q      <= 1'b1;
                        state_q     <= S_TX;
                    end else begin
                        rtimer_q <= rtimer_q + 32'd1;
                    end
                end
                S_TX: begin
                    if (tx_done) begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    busy_q      <= 1'b0;
                    cmd_valid_q <= 1'b0;
                    state_q     <= S_IDLE;
                end
            endcase
        end
    end

    uart_tx_seq u_tx_seq (
        .clk       (clk),
        .rst       (reset),
        .load_i    (load_q),
        .bytes_i   (reply_q),
        .len_i     (reply_len_q),
        .tx_rdy_i  (tx_rdy),
        .tx_vld_o  (tx_vld),
        .tx_data_o (tx_data),
        .done_o    (tx_done)
    );

    assign busy                     = busy_q;
    assign dbus_cmd_valid           = cmd_valid_q;
    assign dbus_cmd_payload_wr      = cmd_wr_q;
    assign dbus_cmd_payload_address = addr_q;
    assign dbus_cmd_payload_data    = wdata_q;
    assign dbus_cmd_payload_size    = DBUS_SIZE_WORD;

endmodule

// File: tb/tb_uart_dbus_master.sv
// Scoreboard bench for uart_dbus_master: stimulus pushes expected dBus
// commands and reply bytes; negedge monitors pop and compare.
`timescale 1ns/1ps
module tb_uart_dbus_master;

    logic        clk;
    logic        reset;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        tx_rdy;
    logic        tx_vld;
    logic [7:0]  tx_data;
    logic        dbus_cmd_valid;
    logic        dbus_cmd_ready;
    logic        dbus_cmd_payload_wr;
    logic [31:0] dbus_cmd_payload_address;
    logic [31:0] dbus_cmd_payload_data;
    logic [1:0]  dbus_cmd_payload_size;
    logic        dbus_rsp_ready;
    logic        dbus_rsp_error;
    logic [31:0] dbus_rsp_data;
    logic        busy;

    uart_dbus_master #(
        .CLK_FREQ           (100000),
        .BYTE_TIMEOUT_MS    (1),
        .RSP_TIMEOUT_CYCLES (256),
        .WL                 (32)
    ) dut (
        .clk                      (clk),
        .reset                    (reset),
        .rx_valid                 (rx_valid),
        .rx_data                  (rx_data),
        .tx_rdy                   (tx_rdy),
        .tx_vld                   (tx_vld),
        .tx_data                  (tx_data),
        .dbus_cmd_valid           (dbus_cmd_valid),
        .dbus_cmd_ready           (dbus_cmd_ready),
        .dbus_cmd_payload_wr      (dbus_cmd_payload_wr),
        .dbus_cmd_payload_address (dbus_cmd_payload_address),
        .dbus_cmd_payload_data    (dbus_cmd_payload_data),
        .dbus_cmd_payload_size    (dbus_cmd_payload_size),
        .dbus_rsp_ready           (dbus_rsp_ready),
        .dbus_rsp_error           (dbus_rsp_error),
        .dbus_rsp_data            (dbus_rsp_data),
        .busy                     (busy)
    );

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
        int unsigned cycles;
    } cmd_t;

    cmd_t       exp_cmd[$];
    logic [7:0] exp_tx[$];

    int unsigned nchk = 0;
    int unsigned nfail = 0;
    int unsigned ntransfers = 0;
    int unsigned ntx = 0;

    // responder control: 0 = data, 1 = error, 2 = never respond
    int unsigned rsp_mode = 0;
    int unsigned rsp_delay = 2;
    logic [31:0] rsp_word = '0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        nchk++;
        if (act !== req) begin
            nfail++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic send_frame(input logic [71:0] frame, input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            @(posedge clk);
            #1 rx_valid = 1'b1;
            rx_data = frame[8*(n-1-i) +: 8];
            @(posedge clk);
            #1 rx_valid = 1'b0;
        end
    endtask

    task automatic push_tx(input logic [31:0] word, input int unsigned n);
        logic [31:0] w;
        w = word;
        for (int unsigned i = 0; i < n; i++) exp_tx.push_back(w[8*i +: 8]);
    endtask

    task automatic push_cmd(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                            input int unsigned cycles);
        cmd_t c;
        c.wr = wr; c.addr = addr; c.data = data; c.cycles = cycles;
        exp_cmd.push_back(c);
    endtask

    task automatic wait_idle(input string name);
        int unsigned k;
        k = 0;
        while (k < 2000 && !(exp_tx.size() == 0 && exp_cmd.size() == 0 && busy == 1'b0)) begin
            @(negedge clk);
            k++;
        end
        check({name, "_busy_end"}, {31'd0, busy}, 32'd0);
        check({name, "_pending"}, exp_tx.size() + exp_cmd.size(), 32'd0);
    endtask

    // UART transmitter model: tx_rdy stays high for one cycle after a strobe, then drops.
    initial begin
        tx_rdy = 1'b1;
        forever begin
            @(negedge clk);
            if (tx_vld) begin
                @(posedge clk);
                @(posedge clk);
                #1 tx_rdy = 1'b0;
                repeat (6) @(posedge clk);
                #1 tx_rdy = 1'b1;
            end
        end
    end

    // dBus read responder
    initial begin
        dbus_rsp_ready = 1'b0;
        dbus_rsp_error = 1'b0;
        dbus_rsp_data  = '0;
        forever begin
            @(negedge clk);
            if (!reset && dbus_cmd_valid && dbus_cmd_ready && !dbus_cmd_payload_wr && rsp_mode != 2) begin
                repeat (rsp_delay) @(negedge clk);
                dbus_rsp_ready = 1'b1;
                dbus_rsp_error = (rsp_mode == 1);
                dbus_rsp_data  = rsp_word;
                @(negedge clk);
                dbus_rsp_ready = 1'b0;
                dbus_rsp_error = 1'b0;
            end
        end
    end

    // Monitor: command transfers and reply bytes against the scoreboard
    logic        prev_cv = 1'b0;
    logic        prev_tx = 1'b0;
    logic [31:0] a0, d0;
    logic        stable;
    int unsigned streak = 0;
    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_cv = 1'b0;
                prev_tx = 1'b0;
            end else begin
                if (dbus_cmd_valid) begin
                    if (!prev_cv) begin
                        streak = 1; a0 = dbus_cmd_payload_address; d0 = dbus_cmd_payload_data; stable = 1'b1;
                    end else begin
                        streak++;
                        if (dbus_cmd_payload_address !== a0 || dbus_cmd_payload_data !== d0) stable = 1'b0;
                    end
                    if (dbus_cmd_ready) begin
                        cmd_t c;
                        ntransfers++;
                        if (exp_cmd.size() == 0) begin
                            check("cmd_unexpected", dbus_cmd_payload_address, 32'hFFFF_FFFF);
                        end else begin
                            c = exp_cmd.pop_front();
                            check("cmd_wr", {31'd0, dbus_cmd_payload_wr}, {31'd0, c.wr});
                            check("cmd_addr", dbus_cmd_payload_address, c.addr);
                            if (c.wr) check("cmd_data", dbus_cmd_payload_data, c.data);
                            check("cmd_size", {30'd0, dbus_cmd_payload_size}, 32'd2);
                            check("cmd_valid_cycles", streak, c.cycles);
                            check("cmd_stable", {31'd0, stable}, 32'd1);
                        end
                    end
                end
                prev_cv = dbus_cmd_valid;
                if (tx_vld) begin
                    ntx++;
                    check("tx_back_to_back", {31'd0, prev_tx}, 32'd0);
                    if (exp_tx.size() == 0) check("tx_unexpected", {24'd0, tx_data}, 32'hFFFF_FFFF);
                    else check("tx_byte", {24'd0, tx_data}, {24'd0, exp_tx.pop_front()});
                end
                prev_tx = tx_vld;
            end
        end
    end

    initial begin
        int unsigned t0, x0, k;
        reset = 1'b1;
        rx_valid = 1'b0;
        rx_data = '0;
        dbus_cmd_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_tx_vld", {31'd0, tx_vld}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_cmd_valid", {31'd0, dbus_cmd_valid}, 32'd0);
        check("rst_addr", dbus_cmd_payload_address, 32'd0);
        check("rst_size", {30'd0, dbus_cmd_payload_size}, 32'd2);
        reset = 1'b0;

        // write, cmd_ready tied high
        push_cmd(1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 1);
        push_tx(32'h06, 1);
        send_frame(72'h57_00_01_00_00_EF_BE_AD_DE, 9);
        wait_idle("write");

        // read, response two cycles after the transfer
        rsp_mode = 0; rsp_delay = 2; rsp_word = 32'h1234_5678;
        push_cmd(1'b0, 32'h0000_0104, 32'h0, 1);
        push_tx(32'h1234_5678, 4);
        send_frame(72'h52_04_01_00_00, 5);
        wait_idle("read");

        // read, response in the same cycle as the transfer
        rsp_delay = 0; rsp_word = 32'hCAFE_F00D;
        push_cmd(1'b0, 32'h0000_0008, 32'h0, 1);
        push_tx(32'hCAFE_F00D, 4);
        send_frame(72'h52_08_00_00_00, 5);
        wait_idle("read_same_cycle");

        // back-pressure: ready low for 5 valid cycles
        dbus_cmd_ready = 1'b0;
        push_cmd(1'b1, 32'h8000_0020, 32'hA5A5_5A5A, 6);
        push_tx(32'h06, 1);
        x0 = ntransfers;
        send_frame(72'h57_20_00_00_80_5A_5A_A5_A5, 9);
        k = 0;
        while (k < 50 && !dbus_cmd_valid) begin @(negedge clk); k++; end
        check("bp_valid_seen", {31'd0, dbus_cmd_valid}, 32'd1);
        repeat (4) @(posedge clk);
        @(posedge clk);
        #1 dbus_cmd_ready = 1'b1;
        wait_idle("backpressure");
        check("bp_one_transfer", ntransfers - x0, 32'd1);

        // unknown opcode
        push_tx(32'h15, 1);
        send_frame(72'h41, 1);
        wait_idle("bad_opcode");

        // read with error response
        rsp_mode = 1; rsp_delay = 1; rsp_word = 32'h0BAD_0BAD;
        push_cmd(1'b0, 32'h0000_0200, 32'h0, 1);
        push_tx(32'h15, 1);
        send_frame(72'h52_00_02_00_00, 5);
        wait_idle("rsp_error");

        // read with no response at all
        rsp_mode = 2;
        push_cmd(1'b0, 32'h0000_0300, 32'h0, 1);
        push_tx(32'h15, 1);
        send_frame(72'h52_00_03_00_00, 5);
        wait_idle("rsp_timeout");

        // byte timeout mid-frame: silent drop
        rsp_mode = 0; rsp_delay = 2;
        t0 = ntx; x0 = ntransfers;
        send_frame(72'h57_00_01, 3);
        check("to_busy_mid", {31'd0, busy}, 32'd1);
        repeat (150) @(negedge clk);
        check("to_busy_after", {31'd0, busy}, 32'd0);
        check("to_no_cmd", ntransfers - x0, 32'd0);
        check("to_no_tx", ntx - t0, 32'd0);
        rsp_word = 32'h8765_4321;
        push_cmd(1'b0, 32'h0000_0040, 32'h0, 1);
        push_tx(32'h8765_4321, 4);
        send_frame(72'h52_40_00_00_00, 5);
        wait_idle("after_timeout");

        // reset while waiting for a read response
        rsp_mode = 2;
        t0 = ntx;
        push_cmd(1'b0, 32'h0000_0500, 32'h0, 1);
        x0 = ntransfers;
        send_frame(72'h52_00_05_00_00, 5);
        k = 0;
        while (k < 100 && ntransfers == x0) begin @(negedge clk); k++; end
        check("rr_transfer", ntransfers - x0, 32'd1);
        repeat (3) @(posedge clk);
        #3 reset = 1'b1;
        #1;
        check("rr_busy", {31'd0, busy}, 32'd0);
        check("rr_cmd_valid", {31'd0, dbus_cmd_valid}, 32'd0);
        check("rr_tx_vld", {31'd0, tx_vld}, 32'd0);
        check("rr_addr", dbus_cmd_payload_address, 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        rsp_mode = 0;
        repeat (20) @(negedge clk);
        check("rr_no_reply", ntx - t0, 32'd0);
        push_cmd(1'b1, 32'h0000_0010, 32'h1234_5678, 1);
        push_tx(32'h06, 1);
        send_frame(72'h57_10_00_00_00_78_56_34_12, 9);
        wait_idle("after_reset");

        repeat (20) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

endmodule
